// File: rtl/usb_tg_pkg.sv
// Shared types and the next-word function used by both the traffic generator and
// the receive checker, so the two ends can never disagree on the pattern.
package usb_tg_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_INC  = 2'd1,
    MODE_LFSR = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  // Reserved encoding 3 behaves exactly like idle.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    decode_mode = MODE_INC;
      2'd2:    decode_mode = MODE_LFSR;
      default: decode_mode = MODE_IDLE;
    endcase
  endfunction

  // Operates on the low dsize bits of a MAX_W-wide container.
  function automatic logic [MAX_W-1:0] next_word(input logic [MAX_W-1:0] x,
                                                 input mode_e            mode,
                                                 input logic [MAX_W-1:0] taps,
                                                 input int               dsize);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] xm;
    logic             fb;
    mask = (dsize >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << dsize) - 64'd1);
    xm   = x & mask;
    fb   = ^(xm & taps);
    case (mode)
      MODE_INC:  next_word = (xm + 64'd1) & mask;
      // All-zero is the LFSR lock-up state; escape to 1.
      MODE_LFSR: next_word = (xm == '0) ? 64'd1 : (((xm << 1) | {63'd0, fb}) & mask);
      default:   next_word = xm;
    endcase
  endfunction

endpackage

// File: rtl/usb_tg_checker.sv
// Receive-side checker: locks onto the first word seen, then predicts every
// following word and counts mismatches, resynchronising on each received word.
module usb_tg_checker #(
  parameter int               DSIZE     = 16,
  parameter int               CNT_W     = 32,
  parameter logic [DSIZE-1:0] LFSR_TAPS = DSIZE'(16'hB400)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic [1:0]       mode_i,
  output logic             rx_req_o,
  input  logic             rx_gnt_i,
  input  logic [DSIZE-1:0] rx_data_i,
  output logic             locked_o,
  output logic             err_flag_o,
  output logic [CNT_W-1:0] rx_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);
  import usb_tg_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rx_req_q;
  logic             locked_q;
  logic             err_flag_q;
  logic [DSIZE-1:0] exp_q;
  logic [1:0]       mode_prev_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  mode_e            mode;
  logic             rx_fire;
  logic             checking;
  logic             mode_chg;
  logic             mismatch;
  logic [DSIZE-1:0] rx_next;

  assign mode     = mode_e'(mode_i);
  assign rx_fire  = rx_req_q && rx_gnt_i;
  assign checking = (mode == MODE_INC) || (mode == MODE_LFSR);
  assign mode_chg = (mode_i != mode_prev_q);
  // A word arriving with a mode change is treated as a fresh lock, never an error.
  assign mismatch = locked_q && !mode_chg && (rx_data_i != exp_q);
  assign rx_next  = DSIZE'(next_word(MAX_W'(rx_data_i), mode, MAX_W'(LFSR_TAPS), DSIZE));

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_req_q    <= 1'b0;
      locked_q    <= 1'b0;
      err_flag_q  <= 1'b0;
      exp_q       <= '0;
      mode_prev_q <= 2'd0;
      rx_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      rx_req_q    <= 1'b1;
      mode_prev_q <= mode_i;
      if (clr_i) begin
        locked_q   <= 1'b0;
        err_flag_q <= 1'b0;
        rx_cnt_q   <= '0;
        err_cnt_q  <= '0;
      end else begin
        if (mode_chg) begin
          locked_q <= 1'b0;
        end
        if (rx_fire) begin
          rx_cnt_q <= rx_cnt_q + CNT_ONE;
          if (checking) begin
            exp_q    <= rx_next;
            locked_q <= 1'b1;
            if (mismatch) begin
              err_flag_q <= 1'b1;
              if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_q <= err_cnt_q + CNT_ONE;
              end
            end
          end
        end
      end
    end
  end

  assign rx_req_o   = rx_req_q;
  assign locked_o   = locked_q;
  assign err_flag_o = err_flag_q;
  assign rx_cnt_o   = rx_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/usb_traffic_gen_check.sv
// Configurable traffic engine for the ftdi_245fifo user side: paced pattern
// generator on the write port and a self-synchronising checker on the read port.
module usb_traffic_gen_check #(
  parameter int               DSIZE     = 16,
  parameter logic [DSIZE-1:0] LFSR_TAPS = DSIZE'(16'hB400),
  parameter logic [DSIZE-1:0] SEED      = DSIZE'(1),
  parameter int               CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_mode,
  input  logic [15:0]      cfg_burst_len,
  input  logic [15:0]      cfg_gap,
  input  logic             clr,
  output logic             tx_req,
  input  logic             tx_gnt,
  output logic [DSIZE-1:0] tx_data,
  output logic             rx_req,
  input  logic             rx_gnt,
  input  logic [DSIZE-1:0] rx_data,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  import usb_tg_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tx_state_e        state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [15:0]      burst_q, burst_d;
  logic [15:0]      gap_q, gap_d;
  logic [DSIZE-1:0] data_q;
  logic [CNT_W-1:0] tx_cnt_q;

  mode_e            cfg_mode_dec;
  logic             tx_fire;
  logic             burst_end;
  logic             gap_end;

  assign cfg_mode_dec = decode_mode(cfg_mode);
  assign tx_fire      = (state_q == ST_SEND) && tx_gnt;
  // >= keeps a shortened burst/gap setting from running the counter past its end.
  assign burst_end    = (cfg_burst_len != 16'd0) && ((burst_q + 16'd1) >= cfg_burst_len);
  assign gap_end      = (gap_q + 16'd1) >= cfg_gap;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        mode_d  = cfg_mode_dec;
        burst_d = 16'd0;
        gap_d   = 16'd0;
        if (cfg_en && (cfg_mode_dec != MODE_IDLE)) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_fire) begin
          burst_d = burst_end ? 16'd0 : (burst_q + 16'd1);
        end
        if (!cfg_en) begin
          state_d = ST_IDLE;
        end else if (tx_fire && burst_end && (cfg_gap != 16'd0)) begin
          state_d = ST_GAP;
          gap_d   = 16'd0;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_end) begin
          state_d = cfg_en ? ST_SEND : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d = ST_IDLE;
      burst_d = 16'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_IDLE;
      burst_q  <= '0;
      gap_q    <= '0;
      data_q   <= SEED;
      tx_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      if (clr) begin
        data_q   <= SEED;
        tx_cnt_q <= '0;
      end else if (tx_fire) begin
        data_q   <= DSIZE'(next_word(MAX_W'(data_q), mode_q, MAX_W'(LFSR_TAPS), DSIZE));
        tx_cnt_q <= tx_cnt_q + CNT_ONE;
      end
    end
  end

  assign tx_req  = (state_q == ST_SEND);
  assign tx_data = data_q;
  assign tx_cnt  = tx_cnt_q;

  usb_tg_checker #(
    .DSIZE     (DSIZE),
    .CNT_W     (CNT_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_checker (
    .CLK        (CLK),
    .RST        (RST),
    .clr_i      (clr),
    .mode_i     (mode_q),
    .rx_req_o   (rx_req),
    .rx_gnt_i   (rx_gnt),
    .rx_data_i  (rx_data),
    .locked_o   (locked),
    .err_flag_o (err_flag),
    .rx_cnt_o   (rx_cnt),
    .err_cnt_o  (err_cnt)
  );

endmodule

// File: tb/tb_usb_traffic_gen_check.sv
// Directed bench for usb_traffic_gen_check: each task drives one scenario and
// compares outputs against hand-computed values at the falling clock edge.
module tb_usb_traffic_gen_check;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cfg_en;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_burst_len;
  logic [15:0] cfg_gap;
  logic        clr;
  logic        tx_req;
  logic        tx_gnt;
  logic [15:0] tx_data;
  logic        rx_req;
  logic        rx_gnt;
  logic [15:0] rx_data;
  logic        locked;
  logic        err_flag;
  logic [31:0] tx_cnt;
  logic [31:0] rx_cnt;
  logic [31:0] err_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] LFSR_TX [4]  = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
  localparam logic [15:0] RX_W    [5]  = '{16'h0005, 16'h0006, 16'h00FF, 16'h0008, 16'h0009};
  localparam int          RX_E    [5]  = '{0, 0, 1, 2, 2};
  localparam logic [15:0] LF_W    [6]  = '{16'h8000, 16'h0001, 16'hB400, 16'h6800, 16'h0000, 16'h0001};
  localparam int          LF_E    [6]  = '{0, 0, 1, 1, 2, 2};

  always #5 CLK = ~CLK;

  usb_traffic_gen_check dut (
    .CLK           (CLK),
    .RST           (RST),
    .cfg_en        (cfg_en),
    .cfg_mode      (cfg_mode),
    .cfg_burst_len (cfg_burst_len),
    .cfg_gap       (cfg_gap),
    .clr           (clr),
    .tx_req        (tx_req),
    .tx_gnt        (tx_gnt),
    .tx_data       (tx_data),
    .rx_req        (rx_req),
    .rx_gnt        (rx_gnt),
    .rx_data       (rx_data),
    .locked        (locked),
    .err_flag      (err_flag),
    .tx_cnt        (tx_cnt),
    .rx_cnt        (rx_cnt),
    .err_cnt       (err_cnt)
  );

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; cfg_en = 1'b0; cfg_mode = 2'd0; cfg_burst_len = 16'd0; cfg_gap = 16'd0;
    clr = 1'b0; tx_gnt = 1'b0; rx_gnt = 1'b0; rx_data = 16'h0000;
    repeat (3) @(negedge CLK);
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    total++; if (rx_req !== 1'b0) begin bad++; $display("FAIL reset_rx_req: got %b want 0", rx_req); end
    total++; if (tx_data !== 16'h0001) begin bad++; $display("FAIL reset_tx_data: got %h want 0001", tx_data); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL reset_err_flag: got %b want 0", err_flag); end
    total++; if (tx_cnt !== 32'd0) begin bad++; $display("FAIL reset_tx_cnt: got %0d want 0", tx_cnt); end
    total++; if (rx_cnt !== 32'd0) begin bad++; $display("FAIL reset_rx_cnt: got %0d want 0", rx_cnt); end
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    RST = 1'b0;
    @(negedge CLK);
    total++; if (rx_req !== 1'b1) begin bad++; $display("FAIL post_reset_rx_req: got %b want 1", rx_req); end
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL post_reset_tx_req: got %b want 0", tx_req); end
    $display("transaction reset: tx_data=%h rx_req=%b", tx_data, rx_req);
  endtask

  task automatic test_inc_mode();
    cfg_mode = 2'd1; cfg_burst_len = 16'd0; cfg_gap = 16'd0; tx_gnt = 1'b1; cfg_en = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 100; i++) begin
      if (i < 5 || i == 99) begin
        total++;
        if (tx_data !== 16'(i + 1)) begin bad++; $display("FAIL inc_word%0d: got %h want %h", i, tx_data, 16'(i + 1)); end
      end
      @(negedge CLK);
    end
    total++; if (tx_cnt !== 32'd100) begin bad++; $display("FAIL inc_tx_cnt: got %0d want 100", tx_cnt); end
    total++; if (tx_data !== 16'h0065) begin bad++; $display("FAIL inc_after100: got %h want 0065", tx_data); end
    cfg_en = 1'b0; tx_gnt = 1'b0;
    @(negedge CLK);
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL inc_disable_req: got %b want 0", tx_req); end
    $display("transaction inc: tx_cnt=%0d tx_data=%h", tx_cnt, tx_data);
    pulse_clr();
  endtask

  task automatic test_lfsr_loopback();
    pulse_clr();
    cfg_mode = 2'd2; tx_gnt = 1'b1; cfg_en = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 44; i++) begin
      if (i < 4) begin
        total++;
        if (tx_data !== LFSR_TX[i]) begin bad++; $display("FAIL lfsr_tx%0d: got %h want %h", i, tx_data, LFSR_TX[i]); end
      end
      rx_gnt  = tx_req & tx_gnt;
      rx_data = tx_data;
      @(negedge CLK);
    end
    rx_gnt = 1'b0; cfg_en = 1'b0; tx_gnt = 1'b0;
    total++; if (tx_cnt !== 32'd44) begin bad++; $display("FAIL loop_tx_cnt: got %0d want 44", tx_cnt); end
    total++; if (rx_cnt !== 32'd44) begin bad++; $display("FAIL loop_rx_cnt: got %0d want 44", rx_cnt); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL loop_locked: got %b want 1", locked); end
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL loop_err_cnt: got %0d want 0", err_cnt); end
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL loop_err_flag: got %b want 0", err_flag); end
    $display("transaction lfsr_loopback: tx_cnt=%0d rx_cnt=%0d err_cnt=%0d", tx_cnt, rx_cnt, err_cnt);
    @(negedge CLK);
  endtask

  task automatic test_burst_gap();
    logic [13:0] pat;
    pulse_clr();
    cfg_mode = 2'd1; cfg_burst_len = 16'd4; cfg_gap = 16'd3; tx_gnt = 1'b1; cfg_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      pat[13 - i] = tx_req;
    end
    cfg_en = 1'b0;
    total++; if (pat !== 14'b11110001111000) begin bad++; $display("FAIL burst_pattern: got %b want 11110001111000", pat); end
    @(negedge CLK);
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL burst_idle_req: got %b want 0", tx_req); end
    total++; if (tx_cnt !== 32'd8) begin bad++; $display("FAIL burst_tx_cnt: got %0d want 8", tx_cnt); end
    $display("transaction burst_gap: pattern=%b tx_cnt=%0d", pat, tx_cnt);
    cfg_burst_len = 16'd0; cfg_gap = 16'd0;
  endtask

  task automatic test_gnt_toggle();
    pulse_clr();
    cfg_mode = 2'd1; tx_gnt = 1'b1; cfg_en = 1'b1;
    @(negedge CLK);
    for (int k = 1; k <= 6; k++) begin
      total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL toggle_req%0d: got %b want 1", k, tx_req); end
      total++;
      if (tx_data !== 16'(1 + k / 2)) begin bad++; $display("FAIL toggle_data%0d: got %h want %h", k, tx_data, 16'(1 + k / 2)); end
      tx_gnt = (k % 2 == 1);
      @(negedge CLK);
    end
    cfg_en = 1'b0; tx_gnt = 1'b0;
    @(negedge CLK);
    $display("transaction gnt_toggle: tx_data=%h tx_cnt=%0d", tx_data, tx_cnt);
  endtask

  task automatic test_rx_check();
    cfg_mode = 2'd1;
    @(negedge CLK);
    pulse_clr();
    rx_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = RX_W[i];
      @(negedge CLK);
      total++; if (err_cnt !== 32'(RX_E[i])) begin bad++; $display("FAIL rx_err%0d: got %0d want %0d", i, err_cnt, RX_E[i]); end
      total++; if (rx_cnt !== 32'(i + 1)) begin bad++; $display("FAIL rx_cnt%0d: got %0d want %0d", i, rx_cnt, i + 1); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL rx_locked%0d: got %b want 1", i, locked); end
    end
    rx_gnt = 1'b0;
    total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL rx_err_flag: got %b want 1", err_flag); end
    $display("transaction rx_check: rx_cnt=%0d err_cnt=%0d err_flag=%b", rx_cnt, err_cnt, err_flag);
    pulse_clr();
    rx_gnt = 1'b1; rx_data = 16'hFFFF;
    @(negedge CLK);
    rx_data = 16'h0000;
    @(negedge CLK);
    rx_gnt = 1'b0;
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL inc_wrap_err: got %0d want 0", err_cnt); end
    total++; if (rx_cnt !== 32'd2) begin bad++; $display("FAIL inc_wrap_rx_cnt: got %0d want 2", rx_cnt); end
    $display("transaction inc_wrap: FFFF->0000 err_cnt=%0d", err_cnt);
  endtask

  task automatic test_lfsr_check();
    cfg_mode = 2'd2;
    repeat (2) @(negedge CLK);
    pulse_clr();
    rx_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_data = LF_W[i];
      @(negedge CLK);
      total++; if (err_cnt !== 32'(LF_E[i])) begin bad++; $display("FAIL lfsr_chk%0d: got %0d want %0d", i, err_cnt, LF_E[i]); end
    end
    rx_gnt = 1'b0;
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lfsr_chk_locked: got %b want 1", locked); end
    $display("transaction lfsr_check: err_cnt=%0d", err_cnt);
  endtask

  task automatic test_clr_rx();
    cfg_mode = 2'd1;
    repeat (2) @(negedge CLK);
    pulse_clr();
    rx_gnt = 1'b1; rx_data = 16'h0010;
    @(negedge CLK);
    rx_data = 16'h0020;
    @(negedge CLK);
    total++; if (err_cnt !== 32'd1) begin bad++; $display("FAIL clr_pre_err: got %0d want 1", err_cnt); end
    total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL clr_pre_flag: got %b want 1", err_flag); end
    rx_data = 16'h0050; clr = 1'b1;
    @(negedge CLK);
    clr = 1'b0;
    total++; if (rx_cnt !== 32'd0) begin bad++; $display("FAIL clr_rx_cnt: got %0d want 0", rx_cnt); end
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL clr_err_flag: got %b want 0", err_flag); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL clr_locked: got %b want 0", locked); end
    rx_data = 16'h0070;
    @(negedge CLK);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock: got %b want 1", locked); end
    rx_data = 16'h0071;
    @(negedge CLK);
    rx_gnt = 1'b0;
    total++; if (rx_cnt !== 32'd2) begin bad++; $display("FAIL relock_rx_cnt: got %0d want 2", rx_cnt); end
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL relock_err: got %0d want 0", err_cnt); end
    $display("transaction clr_rx: rx_cnt=%0d locked=%b", rx_cnt, locked);
  endtask

  task automatic test_rst_mid_send();
    cfg_mode = 2'd1;
    pulse_clr();
    cfg_burst_len = 16'd0; tx_gnt = 1'b1; cfg_en = 1'b1;
    @(negedge CLK);
    rx_gnt = 1'b1; rx_data = 16'h1234;
    repeat (5) @(negedge CLK);
    total++; if (tx_data !== 16'h0006) begin bad++; $display("FAIL mid_data5: got %h want 0006", tx_data); end
    cfg_mode = 2'd2;
    repeat (3) @(negedge CLK);
    total++; if (tx_data !== 16'h0009) begin bad++; $display("FAIL mode_ignored: got %h want 0009", tx_data); end
    total++; if (tx_cnt !== 32'd8) begin bad++; $display("FAIL mid_tx_cnt: got %0d want 8", tx_cnt); end
    total++; if (rx_cnt !== 32'd8) begin bad++; $display("FAIL mid_rx_cnt: got %0d want 8", rx_cnt); end
    total++; if (err_cnt !== 32'd7) begin bad++; $display("FAIL mid_err_cnt: got %0d want 7", err_cnt); end
    RST = 1'b1;
    @(negedge CLK);
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL rst_tx_req: got %b want 0", tx_req); end
    total++; if (tx_data !== 16'h0001) begin bad++; $display("FAIL rst_tx_data: got %h want 0001", tx_data); end
    total++; if (tx_cnt !== 32'd0) begin bad++; $display("FAIL rst_tx_cnt: got %0d want 0", tx_cnt); end
    total++; if (rx_cnt !== 32'd0) begin bad++; $display("FAIL rst_rx_cnt: got %0d want 0", rx_cnt); end
    total++; if (err_cnt !== 32'd0) begin bad++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL rst_err_flag: got %b want 0", err_flag); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    RST = 1'b0; cfg_en = 1'b0; tx_gnt = 1'b0; rx_gnt = 1'b0;
    @(negedge CLK);
    $display("transaction rst_mid_send: tx_data=%h tx_cnt=%0d", tx_data, tx_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_inc_mode();
    test_lfsr_loopback();
    test_burst_gap();
    test_gnt_toggle();
    test_rx_check();
    test_lfsr_check();
    test_clr_rx();
    test_rst_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
